// File: rtl/alu_add64_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_add64_seq_if
// Description : Request/result bundle for the sequential 64-bit adder.
//               The master drives the request (start, A, B and, when
//               ALU_SEQ_SUB_EN is defined, sub) and observes status and
//               result. The slave is the adder itself.
// Ports       : start           - request an operation
//               A, B [63:0]     - operands, captured on the accept edge
//               sub             - 1 = A-B, 0 = A+B (ALU_SEQ_SUB_EN only)
//               ready           - a start this cycle will be accepted
//               busy            - operation in progress
//               done            - one-cycle pulse, S and flags valid
//               S [63:0]        - result
//               sign, zero, carry, overflow, parity - result flags
// Config      : ALU_SEQ_SUB_EN  - adds the sub request signal
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_add64_seq_if;
  logic        start;
  logic [63:0] A;
  logic [63:0] B;
`ifdef ALU_SEQ_SUB_EN
  logic        sub;
`endif
  logic        ready;
  logic        busy;
  logic        done;
  logic [63:0] S;
  logic        sign;
  logic        zero;
  logic        carry;
  logic        overflow;
  logic        parity;

  modport master (
`ifdef ALU_SEQ_SUB_EN
    output sub,
`endif
    output start, A, B,
    input  ready, busy, done, S, sign, zero, carry, overflow, parity
  );

  modport slave (
`ifdef ALU_SEQ_SUB_EN
    input  sub,
`endif
    input  start, A, B,
    output ready, busy, done, S, sign, zero, carry, overflow, parity
  );
endinterface
`default_nettype wire

// File: rtl/alu_add64_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_add64_seq
// Description : 64-bit add (optionally subtract) built from a single 16-bit
//               adder slice reused over four cycles, least-significant chunk
//               first. Result flags are registered together with the last
//               chunk, so S and flags are all valid while done is high and
//               hold until the next accepted start.
// Ports       : clk             - clock, rising edge
//               rst             - asynchronous active-high reset
//               bus (slave)     - request/result bundle, see alu_add64_seq_if
// Config      : ALU_SEQ_SUB_EN  - when defined, bus.sub selects A-B, done as
//                                 A + ~B + 1; when undefined the block only
//                                 adds and carries no inversion logic.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_add64_seq (
  input  wire logic       clk,
  input  wire logic       rst,
  alu_add64_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [1:0]  r_idx;
  logic        r_carry;
  logic [63:0] r_a;
  // Holds B' (B, or ~B for subtraction) so the slice and the overflow rule
  // see the same operand without re-evaluating the mode each cycle.
  logic [63:0] r_b;
  logic [63:0] r_s;
  logic        r_sign;
  logic        r_zero;
  logic        r_cout;
  logic        r_ovf;
  logic        r_par;

  logic        w_ready;
  logic        w_busy;
  logic        w_done;
  logic        w_accept;
  logic        w_last;
  logic [5:0]  w_lsb;
  logic [15:0] w_a_chunk;
  logic [15:0] w_b_chunk;
  logic [16:0] w_sum;
  logic [63:0] w_s_full;
  logic [63:0] w_b_prime;
  logic        w_cin0;

  // --------------------------------------------------------------------------
  // Operand conditioning at accept time
  // --------------------------------------------------------------------------
`ifdef ALU_SEQ_SUB_EN
  assign w_b_prime = bus.sub ? ~bus.B : bus.B;
  assign w_cin0    = bus.sub;
`else
  assign w_b_prime = bus.B;
  assign w_cin0    = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Shared 16-bit slice
  // --------------------------------------------------------------------------
  assign w_lsb     = {r_idx, 4'b0000};
  assign w_a_chunk = r_a[w_lsb +: 16];
  assign w_b_chunk = r_b[w_lsb +: 16];
  assign w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {16'd0, r_carry};
  assign w_last    = (r_state == ST_RUN) && (r_idx == 2'd3);

  // On the last chunk the upper 16 bits are still in flight, so the flags
  // are computed from the slice output spliced onto the three stored chunks.
  assign w_s_full  = {w_sum[15:0], r_s[47:0]};

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and status outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.start) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // start is deliberately not looked at here: requests during an
        // operation are dropped, not queued.
        w_busy = 1'b1;
        if (r_idx == 2'd3) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_ready      = 1'b1;
        w_done       = 1'b1;
        w_state_next = bus.start ? ST_RUN : ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign w_accept = w_ready & bus.start;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= 2'd0;
      r_carry <= 1'b0;
      r_a     <= 64'd0;
      r_b     <= 64'd0;
      r_s     <= 64'd0;
      r_sign  <= 1'b0;
      r_zero  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_par   <= 1'b0;
    end else if (w_accept) begin
      // S is left untouched here; it is rebuilt chunk by chunk during RUN.
      r_a     <= bus.A;
      r_b     <= w_b_prime;
      r_carry <= w_cin0;
      r_idx   <= 2'd0;
    end else if (r_state == ST_RUN) begin
      r_s[w_lsb +: 16] <= w_sum[15:0];
      r_carry          <= w_sum[16];
      r_idx            <= r_idx + 2'd1;
      if (w_last) begin
        r_sign <= w_s_full[63];
        r_zero <= (w_s_full == 64'd0);
        r_cout <= w_sum[16];
        r_ovf  <= (r_a[63] & r_b[63] & ~w_s_full[63]) |
                  (~r_a[63] & ~r_b[63] & w_s_full[63]);
        r_par  <= ~(^w_s_full);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.ready    = w_ready;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.S        = r_s;
  assign bus.sign     = r_sign;
  assign bus.zero     = r_zero;
  assign bus.carry    = r_cout;
  assign bus.overflow = r_ovf;
  assign bus.parity   = r_par;

endmodule
`default_nettype wire

// File: tb/tb_alu_add64_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_add64_seq
// Description : Self-checking bench for alu_add64_seq. Results are predicted
//               with plain 64-bit arithmetic (unsigned for S/carry, signed
//               for overflow) and compared at the done pulse. Subtraction
//               steps run only when ALU_SEQ_SUB_EN is defined.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_add64_seq;

`ifdef ALU_SEQ_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] s;
    logic        sign;
    logic        zero;
    logic        carry;
    logic        overflow;
    logic        parity;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_add64_seq_if bus ();

  alu_add64_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: mathematical result of A+B or A-B modulo 2^64.
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic sb);
    logic [64:0]        full;
    logic signed [65:0] exact;
    res_t               r;
    if (sb) begin
      full    = {1'b0, a} - {1'b0, b};
      r.carry = (a >= b);
      exact   = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
    end else begin
      full    = {1'b0, a} + {1'b0, b};
      r.carry = full[64];
      exact   = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
    end
    r.s        = full[63:0];
    r.sign     = r.s[63];
    r.zero     = (r.s == 64'd0);
    r.parity   = ($countones(r.s) % 2) == 0;
    r.overflow = (exact != $signed({{2{r.s[63]}}, r.s}));
    return r;
  endfunction

  task automatic drive_ops(input logic [63:0] a, input logic [63:0] b, input logic sb);
    bus.A = a;
    bus.B = b;
`ifdef ALU_SEQ_SUB_EN
    bus.sub = sb;
`else
    if (sb) bus.A = a;
`endif
  endtask

  task automatic check_result(input string tag, input res_t e);
    chk({tag, ".S"},        bus.S,        e.s);
    chk({tag, ".sign"},     bus.sign,     e.sign);
    chk({tag, ".zero"},     bus.zero,     e.zero);
    chk({tag, ".carry"},    bus.carry,    e.carry);
    chk({tag, ".overflow"}, bus.overflow, e.overflow);
    chk({tag, ".parity"},   bus.parity,   e.parity);
  endtask

  // One operation from an idle/done state. With scramble set, operands and
  // start are randomised while the operation runs.
  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic sb, input bit scramble);
    res_t e;
    int   lat;
    e = model(a, b, sb);
    @(negedge clk);
    bus.start = 1'b1;
    drive_ops(a, b, sb);
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, ".busy"},  bus.busy,  1'b1);
    chk({tag, ".ready"}, bus.ready, 1'b0);
    lat = 0;
    while (!bus.done && lat < 8) begin
      if (scramble) begin
        drive_ops({$urandom, $urandom}, {$urandom, $urandom}, HAS_SUB & $urandom_range(0, 1));
        bus.start = $urandom_range(0, 1);
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    chk({tag, ".latency"}, lat, 4);
    chk({tag, ".done"}, bus.done, 1'b1);
    check_result(tag, e);
    @(negedge clk);
    chk({tag, ".done_pulse"}, bus.done,  1'b0);
    chk({tag, ".idle_ready"}, bus.ready, 1'b1);
    chk({tag, ".idle_busy"},  bus.busy,  1'b0);
    chk({tag, ".S_hold"},     bus.S,     e.s);
  endtask

  res_t q[$];
  res_t e_pop;

  initial begin
    int n_done;
    int last_done;
    int seen_done;
    logic [63:0] ra, rb;
    logic        rs;

    bus.start = 1'b0;
    drive_ops(64'd0, 64'd0, 1'b0);

    // ---------------- reset state ----------------
    #2 rst = 1'b1;
    #1;
    chk("rst.ready", bus.ready, 1'b1);
    chk("rst.busy",  bus.busy,  1'b0);
    chk("rst.done",  bus.done,  1'b0);
    chk("rst.S",     bus.S,     64'd0);
    chk("rst.flags", {bus.sign, bus.zero, bus.carry, bus.overflow, bus.parity}, 5'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ---------------- directed ----------------
    do_op("carry_chain", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0);
    do_op("wrap_zero",   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    do_op("ovf_pos",     64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    do_op("ovf_neg",     64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
    if (HAS_SUB) begin
      do_op("sub_borrow", 64'd5, 64'd7, 1'b1, 1'b0);
      do_op("sub_plain",  64'd7, 64'd5, 1'b1, 1'b0);
      do_op("sub_ovf",    64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0);
    end

    // ---------------- random, with disturbance during RUN ----------------
    for (int i = 0; i < 12; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = HAS_SUB & $urandom_range(0, 1);
      do_op($sformatf("rand%0d", i), ra, rb, rs, 1'b1);
    end

    // ---------------- start held high, operands changing each cycle ------
    n_done    = 0;
    last_done = -1;
    @(negedge clk);
    bus.start = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (bus.done) begin
        if (q.size() == 0) begin
          chk("stream.unexpected_done", 64'd1, 64'd0);
        end else begin
          e_pop = q.pop_front();
          chk("stream.S", bus.S, e_pop.s);
          chk("stream.carry", bus.carry, e_pop.carry);
        end
        if (last_done >= 0) chk("stream.interval", cyc - last_done, 5);
        last_done = cyc;
        n_done++;
      end
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = HAS_SUB & $urandom_range(0, 1);
      drive_ops(ra, rb, rs);
      if (bus.ready) q.push_back(model(ra, rb, rs));
      @(negedge clk);
    end
    bus.start = 1'b0;
    for (int w = 0; w < 10 && q.size() != 0; w++) begin
      if (bus.done) begin
        e_pop = q.pop_front();
        chk("stream.S_drain", bus.S, e_pop.s);
        n_done++;
      end
      @(negedge clk);
    end
    chk("stream.pending", q.size(), 0);
    chk("stream.n_done", n_done, 8);

    // ---------------- reset in the middle of RUN ----------------
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    drive_ops(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("abort.busy_before", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort.ready", bus.ready, 1'b1);
    chk("abort.busy",  bus.busy,  1'b0);
    chk("abort.done",  bus.done,  1'b0);
    chk("abort.S",     bus.S,     64'd0);
    chk("abort.flags", {bus.sign, bus.zero, bus.carry, bus.overflow, bus.parity}, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int w = 0; w < 6; w++) begin
      if (bus.done) seen_done++;
      @(negedge clk);
    end
    chk("abort.no_done", seen_done, 0);
    do_op("after_abort", 64'd1, 64'd2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
